// File: rtl/alu_execute_unit.sv
// ALU execute stage. Add, sub, compare and logic ops finish in one cycle.
// Shifts take one bit per cycle under a three-state FSM. Both the input
// side and the result side use a valid/ready handshake.
module alu_execute_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            alu_control_i,
  input  logic                  byte_address_i,
  input  logic [DATA_WIDTH-1:0] src_a_i,
  input  logic [DATA_WIDTH-1:0] src_b_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic [3:0]            byte_en_o
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] work_reg, work_next;
  logic [SHAMT_W-1:0]    count_reg, count_next;
  shift_t                shift_reg, shift_next;
  logic                  baddr_reg, baddr_next;
  logic [DATA_WIDTH-1:0] result_reg;
  logic                  zero_reg;
  logic [3:0]            byte_en_reg;

  logic                  accept;
  logic                  is_shift;
  logic                  multi_cycle;
  shift_t                shift_in;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] alu_value;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  capture;
  logic [DATA_WIDTH-1:0] capture_value;
  logic                  capture_baddr;
  logic [3:0]            capture_be;

  assign accept      = valid_i & ready_o;
  assign shamt       = src_b_i[SHAMT_W-1:0];
  // A shift with a non-zero amount is the only op that needs the SHIFT state.
  assign multi_cycle = is_shift & (shamt != '0);

  // Decode whether the incoming op is a shift, and which kind.
  always_comb begin
    is_shift = 1'b0;
    shift_in = SH_LL;
    case (alu_control_i)
      OP_SLL: begin is_shift = 1'b1; shift_in = SH_LL; end
      OP_SRL: begin is_shift = 1'b1; shift_in = SH_RL; end
      OP_SRA: begin is_shift = 1'b1; shift_in = SH_RA; end
      default: ;
    endcase
  end

  // Single-cycle result; shifts pass operand A through for the shamt==0 case.
  // Unlisted codes fall back to add.
  always_comb begin
    alu_value = src_a_i + src_b_i;
    case (alu_control_i)
      OP_ADD:  alu_value = src_a_i + src_b_i;
      OP_SUB:  alu_value = src_a_i - src_b_i;
      OP_SLT:  alu_value = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a_i) < $signed(src_b_i))};
      OP_SLTU: alu_value = {{(DATA_WIDTH-1){1'b0}}, (src_a_i < src_b_i)};
      OP_XOR:  alu_value = src_a_i ^ src_b_i;
      OP_OR:   alu_value = src_a_i | src_b_i;
      OP_AND:  alu_value = src_a_i & src_b_i;
      OP_SLL, OP_SRL, OP_SRA: alu_value = src_a_i;
      default: ;
    endcase
  end

  // One-bit step of the working value for the shift in flight.
  always_comb begin
    shifted = {work_reg[DATA_WIDTH-2:0], 1'b0};
    case (shift_reg)
      SH_RL:   shifted = {1'b0, work_reg[DATA_WIDTH-1:1]};
      SH_RA:   shifted = {work_reg[DATA_WIDTH-1], work_reg[DATA_WIDTH-1:1]};
      default: ;
    endcase
  end

  // Operand loading, shift stepping, and selecting the value to capture as the result.
  always_comb begin
    work_next     = work_reg;
    count_next    = count_reg;
    shift_next    = shift_reg;
    baddr_next    = baddr_reg;
    capture       = 1'b0;
    capture_value = alu_value;
    capture_baddr = byte_address_i;
    if (accept) begin
      work_next  = src_a_i;
      count_next = shamt;
      shift_next = shift_in;
      baddr_next = byte_address_i;
      capture    = ~multi_cycle;
    end else if (state_reg == SHIFT) begin
      work_next     = shifted;
      count_next    = count_reg - SHAMT_W'(1);
      capture       = (count_reg == SHAMT_W'(1));
      capture_value = shifted;
      capture_baddr = baddr_reg;
    end
  end

  // Byte-lane enables: one lane selected by the low address bits, or all lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_en
    assign capture_be[gi] = ~capture_baddr | (capture_value[1:0] == 2'(gi));
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = multi_cycle ? SHIFT : DONE;
      end
      SHIFT: begin
        if (count_reg == SHAMT_W'(1)) state_next = DONE;
      end
      DONE: begin
        if (accept)       state_next = multi_cycle ? SHIFT : DONE;
        else if (ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: handshake signals.
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_reg)
      IDLE: ready_o = 1'b1;
      DONE: begin
        ready_o = ready_i;
        valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers. The result, zero flag and byte enables only change on capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      work_reg    <= '0;
      count_reg   <= '0;
      shift_reg   <= SH_LL;
      baddr_reg   <= 1'b0;
      result_reg  <= '0;
      zero_reg    <= 1'b1;
      byte_en_reg <= 4'b1111;
    end else begin
      work_reg   <= work_next;
      count_reg  <= count_next;
      shift_reg  <= shift_next;
      baddr_reg  <= baddr_next;
      if (capture) begin
        result_reg  <= capture_value;
        zero_reg    <= (capture_value == '0);
        byte_en_reg <= capture_be;
      end
    end
  end

  assign result_o  = result_reg;
  assign zero_o    = zero_reg;
  assign byte_en_o = byte_en_reg;

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed bench for alu_execute_unit. Expected results are pushed to a
// scoreboard on issue. A monitor pops and checks them on each result handshake.
module tb_alu_execute_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  alu_control_i = 4'b0000;
  logic        byte_address_i = 1'b0;
  logic [31:0] src_a_i = '0;
  logic [31:0] src_b_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic        zero_o;
  logic [3:0]  byte_en_o;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  alu_execute_unit dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .alu_control_i  (alu_control_i),
    .byte_address_i (byte_address_i),
    .src_a_i        (src_a_i),
    .src_b_i        (src_b_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .result_o       (result_o),
    .zero_o         (zero_o),
    .byte_en_o      (byte_en_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every completed result handshake must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && ready_i) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_result: observed %h expected none", result_o);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("[TB] result %h zero %0b be %b (expected %h be %b)",
                 result_o, zero_o, byte_en_o, e.res, e.be);
        check("sb_result", result_o, e.res);
        check("sb_zero", {31'b0, zero_o}, {31'b0, (e.res == 32'h0)});
        check("sb_byte_en", {28'b0, byte_en_o}, {28'b0, e.be});
      end
    end
  end

  // Issue one op (called just after a rising edge), push its expectation,
  // then measure cycles from accept to valid_o.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic baddr, input logic [31:0] exp_res, input logic [3:0] exp_be,
                       input int lat, input string tag);
    int n;
    exp_t e;
    alu_control_i  = op;
    src_a_i        = a;
    src_b_i        = b;
    byte_address_i = baddr;
    valid_i        = 1'b1;
    n = 0;
    while (!ready_o && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    tests++;
    assert (ready_o === 1'b1) else begin
      fails++;
      $error("FAIL %s_ready_timeout: observed %0b expected 1", tag, ready_o);
    end
    e.res = exp_res;
    e.be  = exp_be;
    sb.push_back(e);
    @(posedge clk_i); #1;
    valid_i        = 1'b0;
    src_a_i        = $urandom;
    src_b_i        = $urandom;
    alu_control_i  = 4'b1000;
    byte_address_i = ~baddr;
    n = 1;
    while (!valid_o && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    @(posedge clk_i); #1;
  endtask

  initial begin
    int seen;

    // Reset state
    #12;
    check("rst_valid", {31'b0, valid_o}, 32'h0);
    check("rst_result", result_o, 32'h0);
    check("rst_zero", {31'b0, zero_o}, 32'h1);
    check("rst_byte_en", {28'b0, byte_en_o}, 32'hF);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single-cycle ops
    issue(4'b0000, 32'd5, 32'd7, 1'b0, 32'd12, 4'b1111, 1, "add");

    // sub held in DONE while downstream stalls
    ready_i = 1'b0;
    issue(4'b1000, 32'd9, 32'd9, 1'b0, 32'd0, 4'b1111, 1, "sub");
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {31'b0, valid_o}, 32'h1);
      check("hold_result", result_o, 32'h0);
      check("hold_zero", {31'b0, zero_o}, 32'h1);
      check("hold_ready", {31'b0, ready_o}, 32'h0);
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    #1;
    check("release_ready", {31'b0, ready_o}, 32'h1);
    @(posedge clk_i); #1;
    check("release_idle_valid", {31'b0, valid_o}, 32'h0);

    // Shifts
    issue(4'b1101, 32'h8000_0010, 32'd4, 1'b0, 32'hF800_0001, 4'b1111, 5, "sra");
    issue(4'b0101, 32'h8000_0010, 32'd4, 1'b0, 32'h0800_0001, 4'b1111, 5, "srl");
    issue(4'b0001, 32'h1234_5678, 32'h0000_0020, 1'b0, 32'h1234_5678, 4'b1111, 1, "sll0");
    issue(4'b0001, 32'h0000_0001, 32'd3, 1'b0, 32'h0000_0008, 4'b1111, 4, "sll3");

    // Compares, logic ops, unlisted code
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1, 4'b1111, 1, "slt");
    issue(4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 4'b1111, 1, "sltu");
    issue(4'b1111, 32'd2, 32'd3, 1'b0, 32'd5, 4'b1111, 1, "unlisted");
    issue(4'b0110, 32'h0000_00F0, 32'h0000_000F, 1'b0, 32'h0000_00FF, 4'b1111, 1, "or");
    issue(4'b0111, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 32'h0000_00F0, 4'b1111, 1, "and");

    // Byte-lane enables
    issue(4'b0000, 32'h0000_1000, 32'd3, 1'b1, 32'h0000_1003, 4'b1000, 1, "byte3");
    issue(4'b0000, 32'h0000_1000, 32'd0, 1'b1, 32'h0000_1000, 4'b0001, 1, "byte0");
    issue(4'b0001, 32'h0000_0001, 32'd1, 1'b1, 32'h0000_0002, 4'b0100, 2, "byte_sll");

    // Back-to-back: new op accepted in the same cycle the old result drains
    ready_i = 1'b0;
    issue(4'b0000, 32'd1, 32'd1, 1'b0, 32'd2, 4'b1111, 1, "b2b_first");
    ready_i        = 1'b1;
    alu_control_i  = 4'b0100;
    src_a_i        = 32'h0000_00F0;
    src_b_i        = 32'h0000_00FF;
    byte_address_i = 1'b0;
    valid_i        = 1'b1;
    #1;
    check("b2b_ready", {31'b0, ready_o}, 32'h1);
    begin
      exp_t e;
      e.res = 32'h0000_000F;
      e.be  = 4'b1111;
      sb.push_back(e);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    src_a_i = 32'hDEAD_BEEF;
    check("b2b_valid", {31'b0, valid_o}, 32'h1);
    check("b2b_result", result_o, 32'h0000_000F);
    @(posedge clk_i); #1;

    // Reset in the middle of a 20-cycle shift
    alu_control_i = 4'b0001;
    src_a_i       = 32'h0000_0001;
    src_b_i       = 32'd20;
    valid_i       = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
    end
    check("shift_busy_ready", {31'b0, ready_o}, 32'h0);
    check("shift_busy_valid", {31'b0, valid_o}, 32'h0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("abort_valid", {31'b0, valid_o}, 32'h0);
    check("abort_result", result_o, 32'h0);
    check("abort_ready", {31'b0, ready_o}, 32'h1);
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    #1;
    check("post_rst_ready", {31'b0, ready_o}, 32'h1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) seen++;
    end
    check("no_stale_result", 32'(seen), 32'd0);

    // Unit still works after the abort
    issue(4'b0000, 32'd3, 32'd4, 1'b0, 32'd7, 4'b1111, 1, "post_rst_add");

    repeat (3) @(posedge clk_i);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_execute_unit.md
Name: alu_execute_unit

Overview:
- Execute stage sitting directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code and the byte-address flag, plus two operands from the register-read stage.
- Produces the result, a zero flag for branch resolution, and byte-lane enables for the memory stage.
- Add, sub, compare and logic ops complete in one cycle; shifts run iteratively, one bit per cycle, under a small FSM with valid/ready handshakes on both sides.

Parameters:
DATA_WIDTH, 32, operand/result width; byte-enable logic requires 32.
SHAMT_W, $clog2(DATA_WIDTH), width of the shift amount taken from src_b_i[SHAMT_W-1:0].

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
valid_i  in  1  upstream operation valid
ready_o  out  1  unit can accept an operation this cycle
alu_control_i  in  4  op code: 0000 add, 1000 sub, 0001 sll, 0101 srl, 1101 sra, 0010 slt, 0011 sltu, 0100 xor, 0110 or, 0111 and
byte_address_i  in  1  1 = byte access (lbu/sb), 0 = word or non-memory
src_a_i  in  DATA_WIDTH  operand A
src_b_i  in  DATA_WIDTH  operand B / shift amount
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
result_o  out  DATA_WIDTH  registered result
zero_o  out  1  result_o == 0
byte_en_o  out  4  byte-lane enables for memory stage

Behaviour:
- Reset is asynchronous, active-low (rst_ni=0). Clock is clk_i; single clock domain.
- Reset state: FSM=IDLE, valid_o=0, result_o=0, zero_o=1, byte_en_o=4'b1111, shift counter=0.
- Reset asserted mid-shift aborts the operation immediately. No result is produced.
- FSM states: IDLE, SHIFT, DONE.
- ready_o = (state==IDLE) | (state==DONE & ready_i). Accept occurs when valid_i & ready_o.
- Accept of a non-shift op: result is computed combinationally and registered, then state goes to DONE. valid_o rises the next cycle (latency 1).
- Accept of a shift op (0001/0101/1101):
  - Load operand src_a_i and counter = src_b_i[SHAMT_W-1:0].
  - If counter==0, go to DONE with result = src_a_i (latency 1).
  - Otherwise go to SHIFT.
- SHIFT:
  - Each cycle, shift the working value one bit (sll: zero-fill LSB; srl: zero-fill MSB; sra: replicate MSB) and decrement the counter.
  - On the cycle the counter goes 1 to 0, register the final value and go to DONE.
  - Latency = shamt + 1 cycles from accept to valid_o.
  - valid_i is ignored in SHIFT (ready_o=0).
- DONE:
  - valid_o=1; result_o, zero_o and byte_en_o are held stable until ready_i.
  - ready_i=1 with no new accept: go to IDLE, valid_o=0 next cycle.
  - ready_i=1 with a simultaneous accept: the new op is taken in the same cycle (back-to-back). Next state is DONE (non-shift or shamt 0) or SHIFT.
- Arithmetic:
  - add/sub wrap modulo 2^DATA_WIDTH; no carry or overflow outputs.
  - slt: signed compare; sltu: unsigned compare. Result is zero-extended 0/1.
  - Any unlisted alu_control_i code executes as add.
- zero_o is registered with result_o and equals (result==0).
- byte_en_o:
  - byte_address_i=1: 4'b0001 << result[1:0], registered with the result.
  - byte_address_i=0: 4'b1111.
- Operand inputs are sampled only on accept. Later changes on src_a_i, src_b_i, alu_control_i or byte_address_i have no effect on an in-flight op.

Test Plan:
- Reset release, then valid_i with add 0000, A=5, B=7 -> next cycle valid_o=1, result_o=12, zero_o=0, byte_en_o=1111. ready_i=1 -> IDLE.
- sub 1000, A=9, B=9 with ready_i held 0 for 3 cycles -> result_o=0, zero_o=1, held stable; ready_o=0 until ready_i=1.
- sra 1101, A=32'h8000_0010, B=4 -> valid_o exactly 5 cycles after accept, result_o=32'hF800_0001. srl of the same operands -> 32'h0800_0001. sll shamt 0 -> result=A after 1 cycle.
- slt, A=32'hFFFF_FFFF, B=1 -> result 1; sltu with the same operands -> result 0. Unlisted code 1111, A=2, B=3 -> result 5.
- byte_address_i=1, add A=32'h1000, B=3 -> result 32'h1003, byte_en_o=1000. byte_address_i=1 with result offset 0 -> 0001.
- Back-to-back: in DONE with ready_i=1 and valid_i=1 (xor, A=F0, B=FF) -> accepted the same cycle, next result 0F. Separately, assert rst_ni=0 during a 20-cycle sll -> valid_o=0 immediately; after release, ready_o=1 and no stale result appears.
